phase_accumulator: RTL and testbench

//   Numerically controlled phase source for the wave generator. Produces the 16-bit

---
 rtl/wave_pkg.sv | 19 +
 rtl/sample_tick_divider.sv | 42 ++++
 rtl/phase_accumulator.sv | 118 +++++++++++
 tb/tb_phase_accumulator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared wave-generator constants and the phase accumulator's frequency-word state type.
package wave_pkg;

    // Phase word width expected by the sine lookup input
    localparam int unsigned LUT_PHASE_W  = 16;
    // Sine lookup output sample width
    localparam int unsigned LUT_SAMPLE_W = 12;
    // Default accumulator / tuning-word width
    localparam int unsigned DEF_ACC_W    = 24;
    // Default sample-rate divider width
    localparam int unsigned DEF_DIV_W    = 16;

    // CLEAN: active word is current; PENDING: shadow word waits for the next tick
    typedef enum logic {
        ST_CLEAN   = 1'b0,
        ST_PENDING = 1'b1
    } fcw_state_t;

endpackage

// File: rtl/sample_tick_divider.sv
// Sample-rate divider: emits one tick every (i_div + 1) enabled clocks.
// Ports:
//   i_clk     system clock
//   i_reset   synchronous active-high reset
//   i_enable  1 = count, 0 = hold count and suppress ticks
//   i_sync    restart the period; no tick in that cycle
//   i_div     sample period minus one, in clocks
//   o_tick_c  combinational tick strobe for the current cycle
module sample_tick_divider
    import wave_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick_c
);

    logic [DIV_W-1:0] r_div_cnt;

    // ">=" so that lowering i_div below the running count ticks on the next enabled cycle
    assign o_tick_c = i_enable && !i_sync && (r_div_cnt >= i_div);

    // Period counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt <= '0;
        end else if (i_sync) begin
            r_div_cnt <= '0;
        end else if (i_enable) begin
            if (o_tick_c) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/phase_accumulator.sv
// Numerically controlled phase source feeding the sine lookup.
// Frequency words are double-buffered (shadow -> active) and only take effect on a
// sample tick, so every sample step uses one consistent tuning word.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   enable        run divider/accumulator (0 = freeze; loads and sync still honoured)
//   sync          restart phase at 0 and restart the divider
//   fcw_in        frequency control word, captured by fcw_load
//   fcw_load      capture fcw_in into the shadow register
//   div_in        sample period minus one, in clocks
//   phase_offset  added to the output phase, sampled at tick
//   phase         registered phase word
//   phase_valid   one-cycle strobe: new phase this cycle
//   wrap          with phase_valid: accumulator carried out on this step
module phase_accumulator
    import wave_pkg::*;
#(
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned PHASE_W = LUT_PHASE_W,
    parameter int unsigned DIV_W   = DEF_DIV_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               sync,
    input  logic [ACC_W-1:0]   fcw_in,
    input  logic               fcw_load,
    input  logic [DIV_W-1:0]   div_in,
    input  logic [PHASE_W-1:0] phase_offset,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap
);

    fcw_state_t         r_state;
    fcw_state_t         w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_fcw_shadow;
    logic [ACC_W-1:0]   r_fcw_active;
    logic [ACC_W-1:0]   w_eff;
    logic [ACC_W:0]     w_sum;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic               w_tick;
    logic [PHASE_W-1:0] r_phase;
    logic               r_phase_valid;
    logic               r_wrap;

    sample_tick_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_enable (enable),
        .i_sync   (sync),
        .i_div    (div_in),
        .o_tick_c (w_tick)
    );

    // Pending-load state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and step datapath; a load coincident with a tick stays pending
    always_comb begin
        w_state_nxt = r_state;
        w_eff       = r_fcw_active;
        if (r_state == ST_PENDING) begin
            w_eff = r_fcw_shadow;
        end
        if (fcw_load) begin
            w_state_nxt = ST_PENDING;
        end else if (w_tick) begin
            w_state_nxt = ST_CLEAN;
        end
        w_sum       = {1'b0, r_acc} + {1'b0, w_eff};
        w_phase_nxt = w_sum[ACC_W-1 -: PHASE_W] + phase_offset;
    end

    // Tuning words, accumulator and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc         <= '0;
            r_fcw_shadow  <= '0;
            r_fcw_active  <= '0;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            if (fcw_load) begin
                r_fcw_shadow <= fcw_in;
            end
            if (w_tick) begin
                r_fcw_active <= w_eff;
            end
            // sync outranks the tick (the divider already masks the tick during sync)
            if (sync) begin
                r_acc <= '0;
            end else if (w_tick) begin
                r_acc <= w_sum[ACC_W-1:0];
            end
            if (w_tick) begin
                r_phase <= w_phase_nxt;
            end
            r_phase_valid <= w_tick;
            r_wrap        <= w_tick & w_sum[ACC_W];
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign wrap        = r_wrap;

endmodule

// File: tb/tb_phase_accumulator.sv
module tb_phase_accumulator;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        sync;
    logic [23:0] fcw_in;
    logic        fcw_load;
    logic [15:0] div_in;
    logic [15:0] phase_offset;
    logic [15:0] phase;
    logic        phase_valid;
    logic        wrap;

    int n_checks;
    int n_errors;

    phase_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sync         (sync),
        .fcw_in       (fcw_in),
        .fcw_load     (fcw_load),
        .div_in       (div_in),
        .phase_offset (phase_offset),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect n-1 idle cycles then one strobe with the given phase/wrap
    task automatic expect_strobe(input string tag, input int n, input logic [15:0] ph,
                                 input logic wr);
        for (int i = 0; i < n - 1; i++) begin
            step();
            chk({tag, " idle"}, 32'(phase_valid), 32'd0);
        end
        step();
        chk({tag, " valid"}, 32'(phase_valid), 32'd1);
        chk({tag, " phase"}, 32'(phase), 32'(ph));
        chk({tag, " wrap"}, 32'(wrap), 32'(wr));
    endtask

    // Reset, then load a word with the divider frozen so the first enabled tick uses it
    task automatic reset_and_load(input logic [23:0] w, input logic [15:0] d);
        reset = 1'b1; enable = 1'b0; sync = 1'b0; fcw_load = 1'b0;
        fcw_in = '0; div_in = d; phase_offset = '0;
        step();
        reset = 1'b0; fcw_in = w; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0; enable = 1'b1;
    endtask

    logic [15:0] exp3 [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp3[0] = 16'h4000; exp3[1] = 16'h8000; exp3[2] = 16'hC000;
        exp3[3] = 16'h0000; exp3[4] = 16'h4000;

        // 1: reset state, then one step per clock
        reset = 1'b1; enable = 1'b0; sync = 1'b0; fcw_load = 1'b0;
        fcw_in = '0; div_in = '0; phase_offset = '0;
        step();
        chk("rst phase", 32'(phase), 32'd0);
        chk("rst valid", 32'(phase_valid), 32'd0);
        chk("rst wrap", 32'(wrap), 32'd0);
        reset_and_load(24'h000100, 16'd0);
        for (int i = 1; i <= 4; i++) expect_strobe("t1", 1, 16'(i), 1'b0);

        // 2: divide by 4
        div_in = 16'd3;
        expect_strobe("t2a", 4, 16'h0005, 1'b0);
        expect_strobe("t2b", 4, 16'h0006, 1'b0);

        // 3: quarter-turn steps, wrap on return to zero
        reset_and_load(24'h400000, 16'd0);
        for (int i = 0; i < 5; i++) expect_strobe("t3", 1, exp3[i], (i == 3));

        // 4: shadow load mid-period, then load coincident with tick
        reset_and_load(24'h000100, 16'd7);
        expect_strobe("t4a", 8, 16'h0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4 pre-load idle", 32'(phase_valid), 32'd0);
        end
        fcw_in = 24'h000200; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        chk("t4 load idle", 32'(phase_valid), 32'd0);
        expect_strobe("t4b", 4, 16'h0003, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t4 period idle", 32'(phase_valid), 32'd0);
        end
        fcw_in = 24'h000300; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        chk("t4c coincident valid", 32'(phase_valid), 32'd1);
        chk("t4c coincident phase", 32'(phase), 32'h0005);
        expect_strobe("t4d", 8, 16'h0008, 1'b0);

        // 5: offset, sync restart, enable freeze
        reset_and_load(24'h000100, 16'd0);
        phase_offset = 16'h8000;
        expect_strobe("t5a", 1, 16'h8001, 1'b0);
        expect_strobe("t5b", 1, 16'h8002, 1'b0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t5 sync valid", 32'(phase_valid), 32'd0);
        chk("t5 sync phase hold", 32'(phase), 32'h8002);
        expect_strobe("t5c", 1, 16'h8001, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5 frozen valid", 32'(phase_valid), 32'd0);
            chk("t5 frozen phase", 32'(phase), 32'h8001);
        end
        enable = 1'b1;
        expect_strobe("t5d", 1, 16'h8002, 1'b0);

        // 6: reset mid-run with a pending load
        fcw_in = 24'h000200; fcw_load = 1'b1;
        expect_strobe("t6a", 1, 16'h8003, 1'b0);
        fcw_load = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; phase_offset = '0;
        chk("t6 rst phase", 32'(phase), 32'd0);
        chk("t6 rst valid", 32'(phase_valid), 32'd0);
        chk("t6 rst wrap", 32'(wrap), 32'd0);
        for (int i = 0; i < 3; i++) expect_strobe("t6b", 1, 16'h0000, 1'b0);
        fcw_in = 24'h000100; fcw_load = 1'b1;
        expect_strobe("t6c", 1, 16'h0000, 1'b0);
        fcw_load = 1'b0;
        expect_strobe("t6d", 1, 16'h0001, 1'b0);
        expect_strobe("t6e", 1, 16'h0002, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
